// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// fetch_unit_pkg : shared fetch-stage types, widths and constants
// Revision       : 1.0
// ============================================================================
package fetch_unit_pkg;

   localparam int ADDR_W  = 32;
   localparam int INSTR_W = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [ADDR_W-1:0]  PC_STEP   = 32'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } fetch_state_t;

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// fetch_unit_if : instruction-memory port plus fetch-to-decode handshake
// Revision      : 1.0
// ============================================================================
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               imem_rvalid;

   logic               if_valid;
   logic               if_ready;
   logic [ADDR_W-1:0]  if_pc;
   logic [INSTR_W-1:0] if_instr;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_rvalid,
      output if_valid,
      input  if_ready,
      output if_pc,
      output if_instr
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_rvalid,
      input  if_valid,
      output if_ready,
      input  if_pc,
      input  if_instr
   );

endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : single-outstanding instruction fetch with redirect and kill
// Revision   : 1.0
// ============================================================================
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              stall,
   output logic              misalign,
   fetch_unit_if.master      bus
);

   fetch_state_t       state;
   fetch_state_t       state_nxt;
   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  pc_nxt;
   logic               kill;
   logic               kill_nxt;
   logic               capture;
   logic               xfer;
   logic [ADDR_W-1:0]  pc_out;
   logic [INSTR_W-1:0] instr_out;
   logic               misalign_q;

   assign xfer = (state == ST_HOLD) && !stall && bus.if_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         pc    <= RESET_PC;
         kill  <= 1'b0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         kill  <= kill_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_out    <= '0;
         instr_out <= NOP_INSTR;
      end else if (capture) begin
         pc_out    <= pc;
         instr_out <= bus.imem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= jump && (jump_target[1:0] != 2'b00);
      end
   end

   // A redirect always wins; kill marks an in-flight response that must be dropped.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      kill_nxt  = kill;
      capture   = 1'b0;

      case (state)
         ST_IDLE: begin
            state_nxt = ST_REQ;
         end

         ST_REQ: begin
            if (!stall) begin
               state_nxt = ST_WAIT;
               if (jump) begin
                  kill_nxt = 1'b1;
               end
            end
         end

         ST_WAIT: begin
            if (jump) begin
               if (bus.imem_rvalid) begin
                  kill_nxt  = 1'b0;
                  state_nxt = ST_REQ;
               end else begin
                  kill_nxt  = 1'b1;
               end
            end else if (bus.imem_rvalid) begin
               if (kill) begin
                  kill_nxt  = 1'b0;
                  state_nxt = ST_REQ;
               end else begin
                  capture   = 1'b1;
                  state_nxt = ST_HOLD;
               end
            end
         end

         ST_HOLD: begin
            if (jump) begin
               state_nxt = ST_REQ;
            end else if (xfer) begin
               pc_nxt    = pc + PC_STEP;
               state_nxt = ST_REQ;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (jump) begin
         pc_nxt = word_align(jump_target);
      end
   end

   assign bus.imem_req  = (state == ST_REQ) && !stall;
   assign bus.imem_addr = pc;
   assign bus.if_valid  = (state == ST_HOLD) && !stall;
   assign bus.if_pc     = pc_out;
   assign bus.if_instr  = instr_out;
   assign misalign      = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : directed stimulus with queued expectations for fetch_unit
// Revision      : 1.0
// ============================================================================
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        jump;
   logic [31:0] jump_target;
   logic        stall;
   logic        misalign;
   logic        stray;
   int          lat;

   int checks = 0;
   int failures = 0;

   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_pc_q[$];
   logic [31:0] exp_ins_q[$];

   fetch_unit_if bus();

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .jump        (jump),
      .jump_target (jump_target),
      .stall       (stall),
      .misalign    (misalign),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   // Memory contents: 0 -> 00500093, 4 -> 00500493, 100 -> 00510093, FFFFFFFC -> FFAFFC93
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0050_0093 ^ {a[23:0], 8'h00};
   endfunction

   logic        p1, p2;
   logic [31:0] a1, a2;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1 <= 1'b0; p2 <= 1'b0; a1 <= '0; a2 <= '0;
      end else begin
         p1 <= bus.imem_req;
         a1 <= bus.imem_addr;
         p2 <= p1;
         a2 <= a1;
      end
   end

   assign bus.imem_rvalid = ((lat == 1) ? p1 : p2) | stray;
   assign bus.imem_rdata  = mem_word((lat == 1) ? a1 : a2);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic push_xfer(input logic [31:0] pc, input logic [31:0] ins);
      exp_pc_q.push_back(pc);
      exp_ins_q.push_back(ins);
   endtask

   logic [31:0] mon_addr, mon_pc, mon_ins;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.imem_req) begin
            if (exp_addr_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_req: got addr %h, required no request", bus.imem_addr);
            end else begin
               mon_addr = exp_addr_q.pop_front();
               chk("req_addr", bus.imem_addr, mon_addr);
            end
         end
         if (bus.if_valid && bus.if_ready) begin
            if (exp_pc_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_xfer: got pc %h, required no transfer", bus.if_pc);
            end else begin
               mon_pc  = exp_pc_q.pop_front();
               mon_ins = exp_ins_q.pop_front();
               chk("xfer_pc", bus.if_pc, mon_pc);
               chk("xfer_instr", bus.if_instr, mon_ins);
            end
         end
      end
   end

   task automatic wait_valid();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus.if_valid) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL wait_valid: if_valid 0 after 20 cycles, required 1");
      end
   endtask

   task automatic accept_one();
      wait_valid();
      @(posedge clk); #1 bus.if_ready = 1'b1;
      @(posedge clk); #1 bus.if_ready = 1'b0;
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_imem_req"},  {31'd0, bus.imem_req}, 32'd0);
      chk({tag, "_imem_addr"}, bus.imem_addr, 32'h0000_0000);
      chk({tag, "_if_valid"},  {31'd0, bus.if_valid}, 32'd0);
      chk({tag, "_if_pc"},     bus.if_pc, 32'h0000_0000);
      chk({tag, "_if_instr"},  bus.if_instr, 32'h0000_0013);
      chk({tag, "_misalign"},  {31'd0, misalign}, 32'd0);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      jump = 1'b0; jump_target = '0; stall = 1'b0; stray = 1'b0; lat = 1;
      bus.if_ready = 1'b0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_checks("rst");

      // Cold start with 1-cycle memory
      exp_addr_q.push_back(32'h0);
      push_xfer(32'h0, 32'h0050_0093);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk); chk("idle_no_req", {31'd0, bus.imem_req}, 32'd0);
      @(negedge clk); chk("req_cycle1", {31'd0, bus.imem_req}, 32'd1);
      @(negedge clk); chk("wait_no_valid", {31'd0, bus.if_valid}, 32'd0);
      @(negedge clk); chk("valid_cycle3", {31'd0, bus.if_valid}, 32'd1);
      chk("first_pc", bus.if_pc, 32'h0);
      chk("first_instr", bus.if_instr, 32'h0050_0093);

      // Decode back-pressure keeps the instruction parked
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", {31'd0, bus.if_valid}, 32'd1);
         chk("hold_pc", bus.if_pc, 32'h0);
         chk("hold_instr", bus.if_instr, 32'h0050_0093);
         chk("hold_no_req", {31'd0, bus.imem_req}, 32'd0);
      end

      lat = 2;
      exp_addr_q.push_back(32'h4);
      push_xfer(32'h4, 32'h0050_0493);
      accept_one();
      @(negedge clk); chk("req_after_xfer", {31'd0, bus.imem_req}, 32'd1);

      // Redirect while waiting; stale response arrives one cycle later
      exp_addr_q.push_back(32'h8);
      exp_addr_q.push_back(32'h100);
      accept_one();
      @(posedge clk); #1 jump = 1'b1; jump_target = 32'h0000_0100;
      @(posedge clk); #1 jump = 1'b0;
      @(negedge clk);
      chk("kill_no_valid", {31'd0, bus.if_valid}, 32'd0);
      chk("aligned_no_misalign", {31'd0, misalign}, 32'd0);
      @(negedge clk); chk("kill_no_valid2", {31'd0, bus.if_valid}, 32'd0);
      wait_valid();
      chk("redirect_pc", bus.if_pc, 32'h100);
      chk("redirect_instr", bus.if_instr, 32'h0051_0093);

      // Misaligned redirect from HOLD
      exp_addr_q.push_back(32'h100);
      @(posedge clk); #1 jump = 1'b1; jump_target = 32'h0000_0102;
      @(posedge clk); #1 jump = 1'b0;
      @(negedge clk);
      chk("misalign_pulse", {31'd0, misalign}, 32'd1);
      chk("jump_drops_valid", {31'd0, bus.if_valid}, 32'd0);
      @(negedge clk); chk("misalign_clear", {31'd0, misalign}, 32'd0);
      wait_valid();
      chk("misalign_pc", bus.if_pc, 32'h100);

      // Top-of-memory fetch followed by wrap to zero
      exp_addr_q.push_back(32'hFFFF_FFFC);
      @(posedge clk); #1 jump = 1'b1; jump_target = 32'hFFFF_FFFC;
      @(posedge clk); #1 jump = 1'b0;
      wait_valid();
      chk("top_pc", bus.if_pc, 32'hFFFF_FFFC);
      chk("top_instr", bus.if_instr, 32'hFFAF_FC93);
      lat = 1;
      push_xfer(32'hFFFF_FFFC, 32'hFFAF_FC93);
      @(posedge clk); #1 bus.if_ready = 1'b1;
      @(posedge clk); #1 bus.if_ready = 1'b0; stall = 1'b1;
      @(negedge clk); chk("stall_no_req", {31'd0, bus.imem_req}, 32'd0);
      @(negedge clk); chk("stall_no_req2", {31'd0, bus.imem_req}, 32'd0);
      exp_addr_q.push_back(32'h0);
      @(posedge clk); #1 stall = 1'b0;
      @(negedge clk); chk("wrap_req", {31'd0, bus.imem_req}, 32'd1);
      wait_valid();

      // Stall in HOLD masks if_valid and blocks the transfer
      push_xfer(32'h0, 32'h0050_0093);
      exp_addr_q.push_back(32'h4);
      @(posedge clk); #1 stall = 1'b1; bus.if_ready = 1'b1;
      @(negedge clk); chk("stall_hold_valid", {31'd0, bus.if_valid}, 32'd0);
      @(negedge clk);
      chk("stall_hold_valid2", {31'd0, bus.if_valid}, 32'd0);
      chk("stall_hold_pc", bus.if_pc, 32'h0);
      @(posedge clk); #1 stall = 1'b0;
      @(posedge clk); #1 bus.if_ready = 1'b0;

      // Reset during WAIT, stray response after release
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      reset_checks("rst2");
      exp_addr_q.push_back(32'h0);
      push_xfer(32'h0, 32'h0050_0093);
      @(posedge clk); #1 rst_n = 1'b1; stray = 1'b1;
      @(negedge clk);
      chk("stray_idle_valid", {31'd0, bus.if_valid}, 32'd0);
      chk("stray_idle_req", {31'd0, bus.imem_req}, 32'd0);
      @(negedge clk); chk("post_rst_req", {31'd0, bus.imem_req}, 32'd1);
      @(posedge clk); #1 stray = 1'b0;
      @(negedge clk); chk("stray_no_valid", {31'd0, bus.if_valid}, 32'd0);
      exp_addr_q.push_back(32'h4);
      accept_one();
      wait_valid();
      chk("post_rst_next_pc", bus.if_pc, 32'h4);

      chk("addr_q_drained", exp_addr_q.size(), 32'd0);
      chk("xfer_q_drained", exp_pc_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 jump  input  1  redirect request from JumpController, single-cycle qualified.
REQ-005 jump_target  input  32  redirect address, sampled when jump=1.
REQ-006 stall  input  1  pipeline hold from hazard logic.
REQ-007 imem_req  output  1  instruction-memory read strobe, one cycle per request.
REQ-008 imem_addr  output  32  word-aligned read address, valid when imem_req=1.
REQ-009 imem_rdata  input  32  read data, valid when imem_rvalid=1.
REQ-010 imem_rvalid  input  1  response strobe, exactly one per request, latency >=1 cycle.
REQ-011 if_valid  output  1  fetched instruction available to decode.
REQ-012 if_ready  input  1  decode accepts; transfer when if_valid&if_ready.
REQ-013 if_pc  output  32  PC of presented instruction.
REQ-014 if_instr  output  32  presented instruction word.
REQ-015 misalign  output  1  one-cycle pulse: redirect target had nonzero bits [1:0].

Function
REQ-016 FSM states IDLE, REQ, WAIT, HOLD; state register and pc register are the only control state plus a kill flag.
REQ-017 IDLE: entered on reset; moves to REQ on the first clock edge with rst_n=1.
REQ-018 REQ: when stall=0, imem_req=1, imem_addr=pc, next state WAIT; when stall=1, no request, remain REQ.
REQ-019 WAIT: on imem_rvalid with kill=0, capture imem_rdata into if_instr, pc into if_pc, next HOLD; with kill=1, discard data, clear kill, next REQ.
REQ-020 HOLD: if_valid=1; if_pc/if_instr held stable until transfer; on transfer with stall=0, pc<=pc+4, next REQ.
REQ-021 stall=1 in HOLD blocks transfer: if_valid forced 0 combinationally, state and pc unchanged.
REQ-022 jump has priority over stall, transfer and response: pc<={jump_target[31:2],2'b00}; if_valid=0 from next cycle.
REQ-023 Jump in IDLE or HOLD: next state REQ, presented instruction dropped without transfer.
REQ-024 Jump in REQ while imem_req issues or in WAIT without imem_rvalid: set kill, next WAIT.
REQ-025 Jump in WAIT coincident with imem_rvalid: discard response, kill stays 0, next REQ.
REQ-026 misalign pulses the cycle after a jump with jump_target[1:0]!=0; redirect still proceeds with bits forced to 00.
REQ-027 pc+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-028 Latency with 1-cycle memory: request cycle N, rvalid N+1, if_valid N+2; throughput one instruction per 3 cycles when if_ready=1.

Reset
REQ-029 While rst_n=0: state=IDLE, pc=RESET_PC, kill=0, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP), misalign=0.
REQ-030 Reset asserted mid-WAIT abandons the request; a late imem_rvalid after reset release in IDLE or REQ is ignored.

Structure
REQ-031 FSM state encoding, NOP constant and instruction width belong in the shared processor package.
REQ-032 No sub-module; pc next-value mux is inline.

Verification
REQ-033 Reset release, RESET_PC=0, 1-cycle memory returning 32'h00500093, if_ready=1 -> imem_req at cycle 1 addr 0, if_valid cycle 3 with if_pc=0, if_instr=32'h00500093, next request addr 4.
REQ-034 if_ready=0 for 5 cycles in HOLD -> if_valid=1, if_pc/if_instr unchanged, no imem_req until if_ready=1.
REQ-035 jump=1 target 32'h0000_0100 during WAIT, rvalid one cycle later -> response discarded, if_valid stays 0, next imem_addr=32'h100.
REQ-036 jump target 32'h0000_0102 -> misalign pulse one cycle, next imem_addr=32'h100.
REQ-037 pc=32'hFFFF_FFFC accepted -> next imem_addr=32'h0000_0000.
REQ-038 rst_n deasserted mid-WAIT, then stray rvalid -> all outputs at reset values, first post-reset fetch addr RESET_PC.
